// File: rtl/odesa_pkg.sv
// Shared definitions for the ODESA layer: state encoding, widths and an index-width helper.
package odesa_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SCAN  = 3'd1,
    SPIKE = 3'd2,
    HOLD  = 3'd3,
    REFR  = 3'd4
  } state_t;

  localparam int INPUT_WIDTH  = 9;
  localparam int WEIGHT_WIDTH = 9;
  localparam int VALUE_WIDTH  = INPUT_WIDTH + WEIGHT_WIDTH + 3;

  // Ceiling log2, never below 1 so a counter or index always has at least one bit.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/odesa_wta_spike_if.sv
// Event input and winner output bundle between the neuron array, the WTA stage and the next layer.
interface odesa_wta_spike_if #(
    parameter int p_neurons     = 4,
    parameter int p_value_width = 21,
    parameter int p_idx_width   = 2
);
    // i_valid is a one-cycle event strobe with no ready (events arriving while busy are dropped).
    // o_valid/o_winner/o_value stay stable until a cycle with o_valid && i_ready completes the transfer.
    logic                               i_valid;
    logic [p_neurons*p_value_width-1:0] i_neuron_out;
    logic                               i_ready;
    logic [p_neurons-1:0]               o_spike;
    logic                               o_valid;
    logic [p_idx_width-1:0]             o_winner;
    logic [p_value_width-1:0]           o_value;
    logic                               o_miss;
    logic                               o_drop;
    logic                               o_busy;

    modport master (
        output i_valid, i_neuron_out, i_ready,
        input  o_spike, o_valid, o_winner, o_value, o_miss, o_drop, o_busy
    );

    modport slave (
        input  i_valid, i_neuron_out, i_ready,
        output o_spike, o_valid, o_winner, o_value, o_miss, o_drop, o_busy
    );
endinterface

// File: rtl/wta_cmp_step.sv
// One winner-take-all comparison: a candidate replaces the best when it is non-zero and strictly larger.
module wta_cmp_step #(
    parameter int p_value_width = 21,
    parameter int p_idx_width   = 2
) (
    input  logic [p_value_width-1:0] cand,
    input  logic [p_idx_width-1:0]   cand_idx,
    input  logic [p_value_width-1:0] best,
    input  logic [p_idx_width-1:0]   best_idx,
    output logic                     upd,
    output logic [p_value_width-1:0] new_best,
    output logic [p_idx_width-1:0]   new_idx
);
    // Strict compare keeps the earlier (lower) index on ties.
    assign upd      = (cand != '0) && (cand > best);
    assign new_best = upd ? cand : best;
    assign new_idx  = upd ? cand_idx : best_idx;
endmodule

// File: rtl/odesa_wta_spike.sv
// Sequential winner-take-all over captured neuron outputs: spikes the winner, hands it downstream, then idles refractory.
module odesa_wta_spike
    import odesa_pkg::*;
#(
    parameter int p_neurons     = 4,
    parameter int p_value_width = VALUE_WIDTH,
    parameter int p_idx_width   = clog2(p_neurons),
    parameter int p_refractory  = 4
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    odesa_wta_spike_if.slave bus,
    output state_t o_state
);
    localparam int CW = clog2(p_refractory + 1);
    localparam logic [p_idx_width-1:0] LAST = p_idx_width'(p_neurons - 1);
    localparam logic [CW-1:0] REFR_LOAD = (p_refractory > 0) ? CW'(p_refractory - 1) : '0;
    localparam logic [p_neurons-1:0] ONE = {{(p_neurons-1){1'b0}}, 1'b1};

    state_t                   state;
    logic [p_value_width-1:0] cap [p_neurons];
    logic [p_idx_width-1:0]   idx;
    logic [p_value_width-1:0] best;
    logic [p_idx_width-1:0]   best_idx;
    logic                     found;
    logic [CW-1:0]            refr;

    logic [p_neurons-1:0]     spike_q;
    logic                     valid_q;
    logic [p_idx_width-1:0]   winner_q;
    logic [p_value_width-1:0] value_q;
    logic                     miss_q;
    logic                     drop_q;
    logic                     busy_q;

    logic                     upd;
    logic [p_value_width-1:0] nxt_best;
    logic [p_idx_width-1:0]   nxt_idx;

    wta_cmp_step #(
        .p_value_width(p_value_width),
        .p_idx_width  (p_idx_width)
    ) u_cmp (
        .cand    (cap[idx]),
        .cand_idx(idx),
        .best    (best),
        .best_idx(best_idx),
        .upd     (upd),
        .new_best(nxt_best),
        .new_idx (nxt_idx)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            for (int k = 0; k < p_neurons; k++) cap[k] <= '0;
            idx      <= '0;
            best     <= '0;
            best_idx <= '0;
            found    <= 1'b0;
            refr     <= '0;
            spike_q  <= '0;
            valid_q  <= 1'b0;
            winner_q <= '0;
            value_q  <= '0;
            miss_q   <= 1'b0;
            drop_q   <= 1'b0;
            busy_q   <= 1'b0;
        end else begin
            miss_q <= 1'b0;
            drop_q <= bus.i_valid && (state != IDLE);
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        for (int k = 0; k < p_neurons; k++)
                            cap[k] <= bus.i_neuron_out[k*p_value_width +: p_value_width];
                        best     <= '0;
                        best_idx <= '0;
                        found    <= 1'b0;
                        idx      <= '0;
                        busy_q   <= 1'b1;
                        state    <= SCAN;
                    end
                end
                SCAN: begin
                    if (upd) begin
                        best     <= nxt_best;
                        best_idx <= nxt_idx;
                        found    <= 1'b1;
                    end
                    // The last step decides using the comparator's view, so the spike lands the very next cycle.
                    if (idx == LAST) begin
                        if (found || upd) begin
                            spike_q  <= ONE << nxt_idx;
                            valid_q  <= 1'b1;
                            winner_q <= nxt_idx;
                            value_q  <= nxt_best;
                            state    <= SPIKE;
                        end else begin
                            miss_q <= 1'b1;
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                SPIKE, HOLD: begin
                    spike_q <= '0;
                    if (bus.i_ready) begin
                        valid_q <= 1'b0;
                        if (p_refractory == 0) begin
                            busy_q <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            refr  <= REFR_LOAD;
                            state <= REFR;
                        end
                    end else begin
                        state <= HOLD;
                    end
                end
                REFR: begin
                    if (refr == '0) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        refr <= refr - 1'b1;
                    end
                end
                default: begin
                    busy_q <= 1'b0;
                    state  <= IDLE;
                end
            endcase
        end
    end

    assign bus.o_spike  = spike_q;
    assign bus.o_valid  = valid_q;
    assign bus.o_winner = winner_q;
    assign bus.o_value  = value_q;
    assign bus.o_miss   = miss_q;
    assign bus.o_drop   = drop_q;
    assign bus.o_busy   = busy_q;
    assign o_state      = state;
endmodule

// File: tb/tb_odesa_wta_spike.sv
// Directed and randomized checks of the WTA spike stage against a max-then-first-index reference model.
module tb_odesa_wta_spike;
    import odesa_pkg::*;

    localparam int N = 4;
    localparam int W = 21;
    localparam int I = 2;
    localparam int R = 4;

    logic   clk;
    logic   rst_n;
    state_t dut_state;
    int     n_tests;
    int     n_fail;
    logic [W-1:0] vals [N];

    odesa_wta_spike_if #(.p_neurons(N), .p_value_width(W), .p_idx_width(I)) bus ();

    odesa_wta_spike #(
        .p_neurons(N), .p_value_width(W), .p_idx_width(I), .p_refractory(R)
    ) dut (
        .i_clk  (clk),
        .i_rst_n(rst_n),
        .bus    (bus),
        .o_state(dut_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Winner = largest value; among equal maxima the first index; all-zero means no winner.
    function automatic void model(output bit found, output int widx, output logic [W-1:0] wval);
        logic [W-1:0] mx;
        mx = '0;
        foreach (vals[i]) if (vals[i] > mx) mx = vals[i];
        found = (mx != 0);
        wval  = mx;
        widx  = 0;
        for (int i = N - 1; i >= 0; i--) if (vals[i] == mx) widx = i;
    endfunction

    task automatic check_idle_outputs(input string tag);
        chk({tag, "_spike"}, 32'(bus.o_spike), 0);
        chk({tag, "_valid"}, 32'(bus.o_valid), 0);
        chk({tag, "_winner"}, 32'(bus.o_winner), 0);
        chk({tag, "_value"}, 32'(bus.o_value), 0);
        chk({tag, "_miss"}, 32'(bus.o_miss), 0);
        chk({tag, "_drop"}, 32'(bus.o_drop), 0);
        chk({tag, "_busy"}, 32'(bus.o_busy), 0);
        chk({tag, "_state"}, 32'(dut_state), 32'(IDLE));
    endtask

    // Called just after a rising edge; event strobe in cycle 0, i_ready low for h cycles from the spike,
    // and extra strobes (which must be dropped) in every cycle whose bit is set in mask.
    task automatic run_event(input string name, input int h, input logic [31:0] mask);
        bit           found;
        int           widx;
        logic [W-1:0] wval;
        logic [N*W-1:0] pk;
        int           last;
        logic [N-1:0] e_spike;
        model(found, widx, wval);
        for (int i = 0; i < N; i++) pk[i*W +: W] = vals[i];
        last = found ? (2 + N + R + h) : (N + 1);
        for (int k = 0; k <= last; k++) begin
            bus.i_valid      = (k == 0) || mask[k];
            bus.i_neuron_out = (k == 0) ? pk : {N{W'($urandom)}};
            bus.i_ready      = (k >= N + 1 + h);
            @(negedge clk);
            e_spike = (found && k == N + 1) ? N'(1 << widx) : '0;
            chk($sformatf("%s_spike_c%0d", name, k), 32'(bus.o_spike), 32'(e_spike));
            chk($sformatf("%s_valid_c%0d", name, k), 32'(bus.o_valid),
                32'(found && k >= N + 1 && k <= N + 1 + h));
            chk($sformatf("%s_miss_c%0d", name, k), 32'(bus.o_miss), 32'(!found && k == N + 1));
            chk($sformatf("%s_busy_c%0d", name, k), 32'(bus.o_busy),
                32'(k >= 1 && k < last));
            chk($sformatf("%s_drop_c%0d", name, k), 32'(bus.o_drop), 32'(k >= 1 && mask[k-1]));
            if (found && k >= N + 1) begin
                chk($sformatf("%s_winner_c%0d", name, k), 32'(bus.o_winner), 32'(widx));
                chk($sformatf("%s_value_c%0d", name, k), 32'(bus.o_value), 32'(wval));
            end
            if (k == last) chk({name, "_end_state"}, 32'(dut_state), 32'(IDLE));
            @(posedge clk);
            #1;
        end
        bus.i_valid = 1'b0;
        bus.i_ready = 1'b0;
    endtask

    initial begin
        bit           f;
        int           wi;
        logic [W-1:0] wv;
        int           h;
        logic [31:0]  mask;
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        bus.i_valid      = 1'b0;
        bus.i_ready      = 1'b0;
        bus.i_neuron_out = '0;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_idle_outputs("rst");
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        vals = '{21'd0, 21'd50, 21'd120, 21'd80};
        run_event("basic", 0, 32'h0);
        vals = '{21'd0, 21'd0, 21'd0, 21'd0};
        run_event("allzero", 0, 32'h0);
        vals = '{21'd90, 21'd90, 21'd30, 21'd90};
        run_event("tie", 0, 32'h0);
        vals = '{21'd10, 21'd20, 21'd30, 21'd200};
        run_event("bp", 6, 32'h0);
        // Strobe at cycle 3 (mid-scan) and cycle 7 (refractory).
        vals = '{21'd5, 21'd100, 21'd7, 21'd3};
        run_event("drop", 0, 32'h0000_0088);
        vals = '{21'd0, 21'd0, 21'd9, 21'd0};
        run_event("dropmiss", 0, 32'h0000_0010);
        vals = '{21'h1FFFFF, 21'd1, 21'h1FFFFF, 21'd0};
        run_event("maxval", 2, 32'h0000_0200);

        // Reset in the middle of a scan discards the event.
        vals = '{21'd1, 21'd2, 21'd3, 21'd4};
        bus.i_neuron_out = {vals[3], vals[2], vals[1], vals[0]};
        bus.i_valid = 1'b1;
        bus.i_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.i_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check_idle_outputs("midrst");
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("postrst_spike_c%0d", k), 32'(bus.o_spike), 0);
            chk($sformatf("postrst_valid_c%0d", k), 32'(bus.o_valid), 0);
        end
        @(posedge clk);
        #1;
        bus.i_ready = 1'b0;
        vals = '{21'd7, 21'd3, 21'd11, 21'd2};
        run_event("afterrst", 1, 32'h0);

        // Randomized events
        for (int t = 0; t < 25; t++) begin
            for (int i = 0; i < N; i++) begin
                case ($urandom_range(0, 2))
                    0: vals[i] = '0;
                    1: vals[i] = W'($urandom_range(1, 6));
                    default: vals[i] = W'($urandom);
                endcase
            end
            model(f, wi, wv);
            h = $urandom_range(0, 3);
            mask = '0;
            if ($urandom_range(0, 1) == 1)
                mask[$urandom_range(1, f ? (1 + N + R + h) : N)] = 1'b1;
            run_event($sformatf("rnd%0d", t), h, mask);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/odesa_wta_spike.md
Name: odesa_wta_spike

Overview:
- Downstream stage of the 8-input neuron array in an ODESA layer.
- Captures the thresholded outputs of p_neurons neurons on each input event and scans them sequentially for the winner (largest non-zero value).
- Issues a one-hot spike back to the winning neuron's i_spike, which latches that neuron's level value for weight/threshold learning.
- Presents the winner index and value to the next layer over a valid/ready handshake, then enforces a refractory window.

Parameters:
- p_neurons, 4, number of neurons in the layer (>=2).
- p_value_width, 21, width of each neuron output (p_input_width+p_weight_width+3 with 9/9).
- p_idx_width, 2, width of the winner index; must satisfy 2**p_idx_width >= p_neurons.
- p_refractory, 4, cycles after handshake during which new events are dropped (0 = none).

Ports:
- i_clk  in  1  clock; all logic on rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_valid  in  1  event strobe: neuron outputs are settled this cycle.
- i_neuron_out  in  p_neurons*p_value_width  packed neuron outputs, neuron k at bits [k*W +: W]; 0 = below threshold.
- i_ready  in  1  next layer accepts the winner.
- o_spike  out  p_neurons  one-hot, one-cycle spike to the winning neuron.
- o_valid  out  1  winner available.
- o_winner  out  p_idx_width  winning neuron index.
- o_value  out  p_value_width  winning neuron value.
- o_miss  out  1  one-cycle pulse: event scanned, no neuron above threshold.
- o_drop  out  1  one-cycle pulse: i_valid arrived while not IDLE.
- o_busy  out  1  high in every state except IDLE.

Behaviour:
- Reset, async on i_rst_n low:
  - State returns to IDLE.
  - All outputs go to 0: o_spike, o_valid, o_winner, o_value, o_miss, o_drop, o_busy.
  - Capture register, scan index, best value/index and refractory counter all clear to 0.
  - Reset mid-scan or mid-hold discards the event and issues no spike.
- All outputs come from flops (Moore); there is no combinational input-to-output path.
- States: IDLE, SCAN, SPIKE, HOLD, REFR.
- IDLE:
  - On i_valid, capture i_neuron_out, clear best and found, set idx=0, go to SCAN.
- SCAN (one neuron per cycle, exactly p_neurons cycles):
  - If cap[idx] != 0 and cap[idx] > best, then best<=cap[idx], best_idx<=idx, found<=1.
  - The comparison is strict unsigned, so on a tie the lowest index wins.
  - At idx==p_neurons-1, using the final best: if found, go to SPIKE; else pulse o_miss and go to IDLE.
- SPIKE (one cycle):
  - o_spike[best_idx]=1; o_valid=1; o_winner=best_idx; o_value=best.
  - If i_ready is also high, the handshake completes and the next state is REFR, or IDLE when p_refractory=0. Otherwise go to HOLD.
- HOLD:
  - o_spike=0; o_valid, o_winner and o_value are held stable until i_ready.
  - On i_ready, go to REFR, or IDLE when p_refractory=0.
- REFR:
  - Counter loads p_refractory-1 on entry and decrements each cycle.
  - At 0, go to IDLE; the first accepted event is the cycle after.
- Latency: i_valid in cycle 0 gives SCAN in cycles 1..p_neurons and o_spike in cycle p_neurons+1.
- Drops: i_valid in any non-IDLE state is ignored, pulses o_drop in the following cycle, and leaves the capture register untouched.
- o_valid drops in the cycle after the handshake; o_winner and o_value keep their last values until the next SPIKE.

Decomposition:
- Shared package odesa_pkg holds:
  - the state encoding (IDLE=0, SCAN=1, SPIKE=2, HOLD=3, REFR=4, 3-bit);
  - the value-width constant (input+weight+3);
  - a clog2 function for the index width.
- One sub-module, wta_cmp_step: a combinational step "cand > best and cand != 0" producing update enable, new best and new index. It is reused by a later parallel-tree variant.

Test Plan:
- p_neurons=4, values {0,50,120,80}, i_valid at cycle 0, i_ready=1 → o_spike=4'b0100 at cycle 5 only; o_winner=2, o_value=120, o_valid high only in cycle 5.
- Values {0,0,0,0} → no o_spike; o_miss pulses at cycle 5 (the edge ending the last SCAN cycle); o_valid stays 0; back in IDLE.
- Tie: values {90,90,30,90} → o_winner=0, o_spike=4'b0001.
- Backpressure: winner 3 (value 200), i_ready low for 6 cycles then high → o_valid high 7 cycles with o_winner/o_value stable; o_spike high exactly 1 cycle; o_busy low after 4 REFR cycles.
- Drop: second i_valid at cycle 3 and another during REFR → o_drop pulses for each; first result unaffected; no second spike.
- Reset: i_rst_n low at cycle 3 mid-scan → all outputs 0 immediately; no spike issued; an i_valid after release is processed normally.
